// File: rtl/approx_add_pkg.sv
`timescale 1ns/1ps
// approx_add_pkg
// Shared definitions for the approximate adder pipeline:
//   - default parameter constants
//   - lower_add  : low-part result (OR approximation or exact add) plus the
//                  carry handed to the upper part, packed as {carry, low[31:0]}
//   - approx_sum : joins the upper-part add and the low part into a full sum
//   - abs_diff   : |x - y| on 33-bit values
// The functions work on 32/33-bit containers so that one body serves every
// legal WIDTH (4..32); callers zero-extend and truncate.
package approx_add_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_APPROX_BITS = 4;
  localparam int DEF_CNT_W       = 16;

  function automatic logic [32:0] lower_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          k,
                                            input logic        exact);
    logic [31:0] mask;
    logic [32:0] s;
    logic        c;
    mask = (k == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - k));
    c    = 1'b0;
    if (exact) begin
      s = {1'b0, a & mask} + {1'b0, b & mask};
      if (k != 0) c = s[k];
      s = {c, s[31:0] & mask};
    end else begin
      // The top approximated bit pair doubles as the carry predictor.
      if (k != 0) c = a[k-1] & b[k-1];
      s = {c, (a | b) & mask};
    end
    return s;
  endfunction

  function automatic logic [32:0] approx_sum(input logic [31:0] ua,
                                             input logic [31:0] ub,
                                             input logic        c,
                                             input logic [31:0] lo,
                                             input int          k);
    logic [32:0] up;
    up = {1'b0, ua} + {1'b0, ub} + {32'd0, c};
    return (up << k) | {1'b0, lo};
  endfunction

  function automatic logic [32:0] abs_diff(input logic [32:0] x,
                                           input logic [32:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_add_pipe_if.sv
`timescale 1ns/1ps
// approx_add_pipe_if
// Operand/result handshake bundle for approx_add_pipe.
//   in_valid/in_ready   : operand pair handshake (in_a, in_b, in_exact)
//   out_valid/out_ready : result handshake (out_sum, WIDTH+1 bits)
//   err_cnt, err_max    : approximation error statistics
// Modports: master = producer/consumer side, slave = adder side.
interface approx_add_pipe_if
  import approx_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_exact;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH:0]   err_max;

  modport master (
    output in_valid, in_a, in_b, in_exact, out_ready,
    input  in_ready, out_valid, out_sum, err_cnt, err_max
  );

  modport slave (
    input  in_valid, in_a, in_b, in_exact, out_ready,
    output in_ready, out_valid, out_sum, err_cnt, err_max
  );
endinterface

// File: rtl/approx_pipe_reg.sv
`timescale 1ns/1ps
// approx_pipe_reg
// One valid/ready pipeline slot. Accepts when empty or when its content is
// leaving in the same cycle; holds data stable while stalled.
// Ports: clk, rst (async, active-high), in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data. Parameter DW = payload width.
module approx_pipe_reg
  import approx_add_pkg::*;
#(
  parameter int DW = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= load || (out_valid && !out_ready);
      if (load) out_data <= in_data;
    end
  end

endmodule

// File: rtl/approx_add_pipe.sv
`timescale 1ns/1ps
// approx_add_pipe
// Two-stage lower-part-OR approximate adder with per-transaction exact mode.
//   clk, rst (async, active-high)
//   bus.slave : in_valid/in_ready/in_a/in_b/in_exact,
//               out_valid/out_ready/out_sum, err_cnt, err_max
// Parameters: WIDTH (operand bits), APPROX_BITS (low bits approximated),
//             CNT_W (error counter width).
// Optional feature: define APPROX_ERRSTAT_EN to build the exact reference
// path and the error statistics; otherwise err_cnt/err_max are tied to 0.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  approx_add_pipe_if.slave bus
);

  localparam int K    = APPROX_BITS;
  localparam int LO_W = (K == 0) ? 1 : K;
  localparam int UP_W = WIDTH - K;
`ifdef APPROX_ERRSTAT_EN
  localparam int S1_W = 3 + 2 * LO_W + 2 * UP_W;
`else
  localparam int S1_W = 2 + LO_W + 2 * UP_W;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [32:0]     lw_p0;
  logic [UP_W-1:0] ua_p0, ub_p0;
  logic [S1_W-1:0] data_p0, data_p1;
  logic            rdy_p1, rdy_p2, vld_p1;
  logic            mode_p1, c_p1;
  logic [LO_W-1:0] lo_p1;
  logic [UP_W-1:0] ua_p1, ub_p1;
  logic [32:0]     sum_p1;
  logic            unused_bits;

  // Stage 0: split operands; the mode bit selects OR-approximate or exact
  // low part here so stage 2 runs the same upper add for both modes.
  assign lw_p0 = lower_add(32'(bus.in_a), 32'(bus.in_b), K, bus.in_exact);
  assign ua_p0 = UP_W'(bus.in_a >> K);
  assign ub_p0 = UP_W'(bus.in_b >> K);

`ifdef APPROX_ERRSTAT_EN
  logic [32:0]     lx_p0;
  logic            cx_p1;
  logic [LO_W-1:0] lox_p1;

  assign lx_p0   = lower_add(32'(bus.in_a), 32'(bus.in_b), K, 1'b1);
  assign data_p0 = {bus.in_exact, lw_p0[32], lw_p0[LO_W-1:0], ua_p0, ub_p0,
                    lx_p0[32], lx_p0[LO_W-1:0]};
  assign {mode_p1, c_p1, lo_p1, ua_p1, ub_p1, cx_p1, lox_p1} = data_p1;
`else
  assign data_p0 = {bus.in_exact, lw_p0[32], lw_p0[LO_W-1:0], ua_p0, ub_p0};
  assign {mode_p1, c_p1, lo_p1, ua_p1, ub_p1} = data_p1;
`endif

  // Stage 1 register: low part, upper operands, carry, mode.
  approx_pipe_reg #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (rdy_p1),
    .in_data   (data_p0),
    .out_valid (vld_p1),
    .out_ready (rdy_p2),
    .out_data  (data_p1)
  );

  // rdy_p1 already equals !vld_p1 | (!out_valid | out_ready).
  assign bus.in_ready = rdy_p1 && !rst;

  assign sum_p1 = approx_sum(32'(ua_p1), 32'(ub_p1), c_p1, 32'(lo_p1), K);

  // Stage 2 register: full sum with carry-out.
  approx_pipe_reg #(.DW(WIDTH + 1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p2),
    .in_data   (sum_p1[WIDTH:0]),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_sum)
  );

`ifdef APPROX_ERRSTAT_EN
  logic [32:0]      ref_p1, err_p1;
  logic [WIDTH:0]   errw_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic [WIDTH:0]   max_p2;

  assign ref_p1  = approx_sum(32'(ua_p1), 32'(ub_p1), cx_p1, 32'(lox_p1), K);
  assign err_p1  = abs_diff(ref_p1, sum_p1);
  assign errw_p1 = err_p1[WIDTH:0];

  // Statistics update on the same edge the result enters stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p2 <= '0;
      max_p2 <= '0;
    end else if (vld_p1 && rdy_p2 && !mode_p1) begin
      if (errw_p1 != '0)    cnt_p2 <= sat_inc(cnt_p2);
      if (errw_p1 > max_p2) max_p2 <= errw_p1;
    end
  end

  assign bus.err_cnt = cnt_p2;
  assign bus.err_max = max_p2;
  assign unused_bits = ^{lw_p0, lx_p0, sum_p1, ref_p1, err_p1};
`else
  assign bus.err_cnt = '0;
  assign bus.err_max = '0;
  assign unused_bits = ^{lw_p0, sum_p1, mode_p1, sat_inc('0)};
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
`timescale 1ns/1ps
// tb_approx_add_pipe
// Directed bench for approx_add_pipe with WIDTH=8, APPROX_BITS=4, CNT_W=2.
// Statistics expectations apply when APPROX_ERRSTAT_EN is defined; otherwise
// err_cnt/err_max are expected to read 0.
module tb_approx_add_pipe;
  localparam int WIDTH = 8;
  localparam int K     = 4;
  localparam int CNT_W = 2;
`ifdef APPROX_ERRSTAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  approx_add_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  approx_add_pipe #(.WIDTH(WIDTH), .APPROX_BITS(K), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Stream vectors: {a, b, exact, expected sum} worked out by hand.
  logic [7:0] va [10] = '{8'h12, 8'h3C, 8'hFF, 8'h9A, 8'h80, 8'h77, 8'hF0, 8'hC9, 8'h55, 8'h01};
  logic [7:0] vb [10] = '{8'h34, 8'h05, 8'h01, 8'h6B, 8'h80, 8'h88, 8'h0F, 8'hA9, 8'hAA, 8'h01};
  logic       vx [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] ve [10] = '{9'h046, 9'h03D, 9'h100, 9'h10B, 9'h100, 9'h0FF, 9'h0FF, 9'h179, 9'h0FF, 9'h002};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
    return STAT_ON ? 32'(v) : 32'd0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ex);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_exact = ex;
    @(negedge clk);
    check_eq("send_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic ex, input logic [8:0] exp_sum,
                            input int exp_cnt, input int exp_max);
    send(a, b, ex);
    @(negedge clk);
    check_eq({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
    check_eq({tag, "_cnt"}, 32'(bus.err_cnt), stat(exp_cnt));
    check_eq({tag, "_max"}, 32'(bus.err_max), stat(exp_max));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, n_out;
    logic [3:0] pat;
    pat = 4'b1001;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_exact  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("rst_out_sum",   32'(bus.out_sum),   32'd0);
    check_eq("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    check_eq("rst_err_max",   32'(bus.err_max),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single transactions: OR approximation, carry predictor, exact overflow.
    run_single("or_low",  8'h0F, 8'h01, 1'b0, 9'h00F, 1, 1);
    run_single("carry",   8'h08, 8'h08, 1'b0, 9'h018, 2, 8);
    run_single("exact_ff", 8'hFF, 8'hFF, 1'b1, 9'h1FE, 2, 8);

    // Back-to-back stream with out_ready pattern 1-0-0-1.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      bus.in_valid = (sent < 10);
      if (sent < 10) begin
        bus.in_a     = va[sent];
        bus.in_b     = vb[sent];
        bus.in_exact = vx[sent];
      end
      bus.out_ready = pat[cyc % 4];
      @(negedge clk);
      check_eq("stream_in_ready", 32'(bus.in_ready),
               32'(!((sent - recv) == 2 && !bus.out_ready)));
      if (bus.out_valid) begin
        if (recv < 10) begin
          check_eq("stream_sum", 32'(bus.out_sum), 32'(ve[recv]));
          if (bus.out_ready) recv++;
        end else begin
          check_eq("stream_extra_result", 32'd1, 32'd0);
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("stream_count", 32'(recv), 32'd10);
    @(negedge clk);
    check_eq("stream_err_cnt", 32'(bus.err_cnt), stat(3));
    check_eq("stream_err_max", 32'(bus.err_max), stat(8));
    @(posedge clk);
    #1;

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b1);
    send(8'h44, 8'h08, 1'b0);
    @(negedge clk);
    check_eq("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid",  32'(bus.out_valid), 32'd0);
    check_eq("rst_async_sum",    32'(bus.out_sum),   32'd0);
    check_eq("rst_async_ready",  32'(bus.in_ready),  32'd0);
    check_eq("rst_async_errcnt", 32'(bus.err_cnt),   32'd0);
    check_eq("rst_async_errmax", 32'(bus.err_max),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h21, 8'h12, 1'b1);
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        n_out++;
        check_eq("rst_new_sum", 32'(bus.out_sum), 32'h033);
      end
      @(posedge clk);
      #1;
    end
    check_eq("rst_one_result", 32'(n_out), 32'd1);

    // Counter saturation: five erroneous approximate adds, CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      run_single("sat", 8'h08, 8'h08, 1'b0, 9'h018, (i + 1 > 3) ? 3 : i + 1, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
